// File: rtl/free_to_onehot_arb_pkg.sv
// free_to_onehot_arb_pkg: shared arbitration types and helpers.
// Contents: state_t FSM encoding, idx_w() index width, onehot_to_idx() encoder.
package free_to_onehot_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RTZ  = 2'd2
    } state_t;

    // Index width that stays at least one bit wide for any legal N.
    function automatic int idx_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

    // OR-ing the positions of set bits yields the index when the input is one-hot.
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++)
            if (v[i])
                idx = idx | 5'(i);
        return idx;
    endfunction

endpackage

// File: rtl/free_to_onehot_arb_rr_pick.sv
// free_to_onehot_arb_rr_pick: combinational winner selection.
// Ports: req (N request levels), ptr (round-robin start index),
//        gnt (one-hot winner, zero if no request), gnt_idx (winner index).
module free_to_onehot_arb_rr_pick
    import free_to_onehot_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter bit RR = 1'b1
) (
    input  logic [N-1:0]         req,
    input  logic [idx_w(N)-1:0]  ptr,
    output logic [N-1:0]         gnt,
    output logic [idx_w(N)-1:0]  gnt_idx
);
    localparam int W = idx_w(N);

    logic [N-1:0]   mask;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] low;
    logic [31:0]    g32;

    // Lower half holds requests at or above ptr, upper half the full set, so the
    // lowest set bit of the doubled vector is the first requester after wrap.
    always_comb begin
        mask    = RR ? ~((N'(1) << ptr) - N'(1)) : '1;
        dbl     = {req, req & mask};
        low     = dbl & (-dbl);
        gnt     = low[N-1:0] | low[2*N-1:N];
        g32     = '0;
        g32[N-1:0] = gnt;
        gnt_idx = W'(onehot_to_idx(g32));
    end

endmodule

// File: rtl/free_to_onehot_arb.sv
// free_to_onehot_arb: N four-phase request channels into one N-rail one-hot flow.
// Ports: clk, init_n (async active-low reset), req (channel requests),
//        comp (per-channel completion), onehot (output rails, zero = NULL),
//        onehot_comp (consumer completion), busy (not IDLE),
//        last_grant (index of the most recent winner).
module free_to_onehot_arb
    import free_to_onehot_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter bit RR = 1'b1
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         comp,
    output logic [N-1:0]         onehot,
    input  logic                 onehot_comp,
    output logic                 busy,
    output logic [idx_w(N)-1:0]  last_grant
);
    localparam int W = idx_w(N);

    state_t         state;
    logic [W-1:0]   ptr;
    logic [N-1:0]   gnt;
    logic [W-1:0]   gnt_idx;

    free_to_onehot_arb_rr_pick #(.N(N), .RR(RR)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state      <= IDLE;
            onehot     <= '0;
            comp       <= '0;
            busy       <= 1'b0;
            last_grant <= '0;
            ptr        <= '0;
        end else begin
            case (state)
                IDLE: if (|req && !onehot_comp) begin
                    onehot     <= gnt;
                    comp       <= gnt;
                    last_grant <= gnt_idx;
                    busy       <= 1'b1;
                    ptr        <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + W'(1);
                    state      <= DATA;
                end
                DATA: if (onehot_comp) begin
                    onehot <= '0;
                    state  <= RTZ;
                end
                // comp is one-hot on the winner, so req & comp isolates req[w].
                RTZ: if (!(|(req & comp)) && !onehot_comp) begin
                    comp  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
